// File: rtl/uart_rx_fifo_if.sv
// Consumer-side bundle of the UART receiver: show-ahead FIFO read port plus status flags.
// slave is the receiver side; master is the consumer that drains the FIFO.
interface uart_rx_fifo_if #(parameter int CNT_W = 5);
  logic             rd_en;
  logic [7:0]       rd_data;
  logic             empty;
  logic             full;
  logic [CNT_W-1:0] count;
  logic             frame_err;
  logic             overflow;
  logic             busy;

  modport master (
    output rd_en,
    input  rd_data, empty, full, count, frame_err, overflow, busy
  );

  modport slave (
    input  rd_en,
    output rd_data, empty, full, count, frame_err, overflow, busy
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 2-flop input synchronizer feeding a show-ahead byte FIFO.
// Byte lands on rd_data one edge after the stop-bit sample; a push into a full FIFO without a pop is dropped and latches overflow.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 186,
  parameter int FIFO_DEPTH   = 16,
  parameter int CNT_W        = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         uart_port_di,
  uart_rx_fifo_if.slave rx_if
);

  localparam int TMR_W = $clog2(CLKS_PER_BIT);
  localparam int AW    = CNT_W - 1;
  localparam logic [TMR_W-1:0] HALF_T = TMR_W'(CLKS_PER_BIT / 2);
  localparam logic [TMR_W-1:0] LAST_T = TMR_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_n;
  logic [TMR_W-1:0] timer, timer_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shreg, shreg_n;
  logic             rx_meta, rx_s;
  logic             push_req, ferr_n;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [CNT_W-1:0] wr_ptr, rd_ptr;
  logic             empty, full, do_pop, do_push;
  logic             frame_err_q, overflow_q;

  // Preset high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= uart_port_di;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      timer       <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      bit_idx     <= bit_idx_n;
      shreg       <= shreg_n;
      frame_err_q <= ferr_n;
    end
  end

  always_comb begin
    state_n   = state;
    timer_n   = timer + 1'b1;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    push_req  = 1'b0;
    ferr_n    = 1'b0;
    case (state)
      IDLE: begin
        timer_n = '0;
        if (!rx_s) state_n = START;
      end
      START: begin
        if (timer == HALF_T) begin
          timer_n   = '0;
          bit_idx_n = '0;
          state_n   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (timer == LAST_T) begin
          timer_n          = '0;
          shreg_n[bit_idx] = rx_s;
          bit_idx_n        = bit_idx + 1'b1;
          if (bit_idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (timer == LAST_T) begin
          timer_n  = '0;
          state_n  = IDLE;
          push_req = rx_s;
          ferr_n   = !rx_s;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_pop  = rx_if.rd_en && !empty;
  // When full, a same-cycle pop frees the slot being written.
  assign do_push = push_req && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= shreg;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (push_req && !do_push) overflow_q <= 1'b1;
    end
  end

  assign rx_if.rd_data   = mem[rd_ptr[AW-1:0]];
  assign rx_if.empty     = empty;
  assign rx_if.full      = full;
  assign rx_if.count     = wr_ptr - rd_ptr;
  assign rx_if.frame_err = frame_err_q;
  assign rx_if.overflow  = overflow_q;
  assign rx_if.busy      = (state != IDLE);

endmodule
